isq_issue_skid_pipe: RTL and testbench

//  Issue-to-execute pipeline stage directly downstream of the age-ordered issue queue.

---
 rtl/isq_pkg.sv | 34 +++
 rtl/isq_skid_slot.sv | 26 ++
 rtl/isq_issue_skid_pipe.sv | 161 ++++++++++++++++
 tb/tb_isq_issue_skid_pipe.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isq_pkg.sv
// Shared types and helpers for the issue-to-execute skid pipeline.
package isq_pkg;

    localparam int unsigned DATA_WIDTH  = 248;
    localparam int unsigned COND_WIDTH  = 2;
    localparam int unsigned INDEX_WIDTH = 4;
    localparam int unsigned ROBID_W     = 7;
    localparam int unsigned ROBID_LSB   = 241;
    localparam int unsigned ROBID_IDX_W = ROBID_W - 1;
    localparam int unsigned PERF_W      = 32;

    localparam logic [1:0] ROB_STATE_NORMAL    = 2'd0;
    localparam logic [1:0] ROB_STATE_ROLLIBACK = 2'd1;
    localparam logic [1:0] ROB_STATE_RECOVER   = 2'd2;
    localparam logic [1:0] ROB_STATE_STALL     = 2'd3;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]  data;
        logic [COND_WIDTH-1:0]  condition;
        logic [INDEX_WIDTH-1:0] index;
    } isq_entry_t;

    // Wrap bit flips every pass through the ROB; an equal robid is not younger.
    function automatic logic robid_younger(input logic [ROBID_W-1:0] entry_robid,
                                           input logic [ROBID_W-1:0] flush_robid);
        return entry_robid[ROBID_W-1] ^ flush_robid[ROBID_W-1]
             ^ (flush_robid[ROBID_IDX_W-1:0] < entry_robid[ROBID_IDX_W-1:0]);
    endfunction

    function automatic logic [ROBID_W-1:0] entry_robid(input isq_entry_t e);
        return e.data[ROBID_LSB +: ROBID_W];
    endfunction

endpackage

// File: rtl/isq_skid_slot.sv
// One valid+entry holding register; load wins over clear.
module isq_skid_slot
    import isq_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       load,
    input  logic       clear,
    input  isq_entry_t d_entry,
    output logic       q_valid,
    output isq_entry_t q_entry
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q_valid <= 1'b0;
            q_entry <= '0;
        end else if (load) begin
            q_valid <= 1'b1;
            q_entry <= d_entry;
        end else if (clear) begin
            q_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/isq_issue_skid_pipe.sv
// Issue-to-execute 2-entry skid stage with rollback flush filtering.
// Define ISSUE_PIPE_PERF_CNT_EN to add issued/stall/killed performance counters.
module isq_issue_skid_pipe
    import isq_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic [COND_WIDTH-1:0]  in_condition,
    input  logic [INDEX_WIDTH-1:0] in_index,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic [COND_WIDTH-1:0]  out_condition,
    output logic [INDEX_WIDTH-1:0] out_index,
    input  logic [1:0]             rob_state,
    input  logic                   flush_valid,
    input  logic [ROBID_W-1:0]     flush_robid,
    output logic [1:0]             occupancy
`ifdef ISSUE_PIPE_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0]      perf_issued,
    output logic [PERF_W-1:0]      perf_stall,
    output logic [PERF_W-1:0]      perf_killed
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic       main_valid, skid_valid;
    isq_entry_t main_entry, skid_entry, in_entry;
    logic       kill, main_young, skid_young, in_young;
    logic       accept, leave;
    logic       a_v, a_y, b_v, b_y, a_keep, b_keep, in_keep;
    isq_entry_t a_e, b_e;
    logic       main_d_v, skid_d_v;
    isq_entry_t main_d_e, skid_d_e;

    assign in_entry   = '{data: in_data, condition: in_condition, index: in_index};
    assign kill       = flush_valid && (rob_state == ROB_STATE_ROLLIBACK);
    assign main_young = robid_younger(entry_robid(main_entry), flush_robid);
    assign skid_young = robid_younger(entry_robid(skid_entry), flush_robid);
    assign in_young   = robid_younger(entry_robid(in_entry), flush_robid);

    assign in_ready      = !skid_valid;
    assign out_valid     = main_valid && !(kill && main_young);
    assign out_data      = main_entry.data;
    assign out_condition = main_entry.condition;
    assign out_index     = main_entry.index;
    assign occupancy     = 2'(state_q);

    assign accept = in_valid && in_ready;
    assign leave  = out_valid && out_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= ST_EMPTY;
        else          state_q <= state_d;
    end

    // Next state: retire head, filter flushed entries, compact, then append input.
    always_comb begin
        a_v      = main_valid;
        a_e      = main_entry;
        a_y      = main_young;
        b_v      = skid_valid;
        b_e      = skid_entry;
        b_y      = skid_young;
        main_d_v = 1'b0;
        main_d_e = in_entry;
        skid_d_v = 1'b0;
        skid_d_e = in_entry;
        state_d  = state_q;

        if (leave) begin
            a_v = skid_valid;
            a_e = skid_entry;
            a_y = skid_young;
            b_v = 1'b0;
        end

        a_keep  = a_v && !(kill && a_y);
        b_keep  = b_v && !(kill && b_y);
        in_keep = accept && !(kill && in_young);

        // accept implies the skid was empty, so at most two survivors exist
        if (a_keep) begin
            main_d_v = 1'b1;
            main_d_e = a_e;
            if (b_keep) begin
                skid_d_v = 1'b1;
                skid_d_e = b_e;
            end else if (in_keep) begin
                skid_d_v = 1'b1;
            end
        end else if (b_keep) begin
            main_d_v = 1'b1;
            main_d_e = b_e;
            skid_d_v = in_keep;
        end else if (in_keep) begin
            main_d_v = 1'b1;
        end

        unique case ({main_d_v, skid_d_v})
            2'b11:   state_d = ST_FULL;
            2'b10:   state_d = ST_ONE;
            default: state_d = ST_EMPTY;
        endcase
    end

    isq_skid_slot u_main (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (main_d_v),
        .clear   (!main_d_v),
        .d_entry (main_d_e),
        .q_valid (main_valid),
        .q_entry (main_entry)
    );

    isq_skid_slot u_skid (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (skid_d_v),
        .clear   (!skid_d_v),
        .d_entry (skid_d_e),
        .q_valid (skid_valid),
        .q_entry (skid_entry)
    );

    a_occ_legal: assert property (@(posedge clock) disable iff (!reset_n)
        (state_q != 2'd3));
    a_occ_match: assert property (@(posedge clock) disable iff (!reset_n)
        (2'(state_q) == ({1'b0, main_valid} + {1'b0, skid_valid})) && (!skid_valid || main_valid));

`ifdef ISSUE_PIPE_PERF_CNT_EN
    logic [1:0] kill_cnt;

    assign kill_cnt = {1'b0, a_v && kill && a_y} + {1'b0, b_v && kill && b_y}
                    + {1'b0, accept && kill && in_young};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_issued <= '0;
            perf_stall  <= '0;
            perf_killed <= '0;
        end else begin
            perf_issued <= perf_issued + PERF_W'(leave);
            perf_stall  <= perf_stall + PERF_W'(out_valid && !out_ready);
            perf_killed <= perf_killed + PERF_W'(kill_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_isq_issue_skid_pipe.sv
// Scoreboard bench for isq_issue_skid_pipe: negedge monitor plus directed scenario tasks.
module tb_isq_issue_skid_pipe;
    import isq_pkg::*;

    logic                   clock = 1'b0;
    logic                   reset_n;
    logic                   in_valid, in_ready;
    logic [DATA_WIDTH-1:0]  in_data;
    logic [COND_WIDTH-1:0]  in_condition;
    logic [INDEX_WIDTH-1:0] in_index;
    logic                   out_valid, out_ready;
    logic [DATA_WIDTH-1:0]  out_data;
    logic [COND_WIDTH-1:0]  out_condition;
    logic [INDEX_WIDTH-1:0] out_index;
    logic [1:0]             rob_state;
    logic                   flush_valid;
    logic [ROBID_W-1:0]     flush_robid;
    logic [1:0]             occupancy;
`ifdef ISSUE_PIPE_PERF_CNT_EN
    logic [31:0] perf_issued, perf_stall, perf_killed;
    logic [31:0] m_issued, m_stall, m_killed;
`endif

    int total = 0;
    int bad   = 0;
    isq_entry_t sb_q[$];
    isq_entry_t keep_q[$];

    always #5 clock = ~clock;

    isq_issue_skid_pipe dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_condition  (in_condition),
        .in_index      (in_index),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_condition (out_condition),
        .out_index     (out_index),
        .rob_state     (rob_state),
        .flush_valid   (flush_valid),
        .flush_robid   (flush_robid),
        .occupancy     (occupancy)
`ifdef ISSUE_PIPE_PERF_CNT_EN
        ,
        .perf_issued   (perf_issued),
        .perf_stall    (perf_stall),
        .perf_killed   (perf_killed)
`endif
    );

    function automatic logic tb_younger(input logic [6:0] e, input logic [6:0] f);
        return e[6] ^ f[6] ^ (f[5:0] < e[5:0]);
    endfunction

    function automatic logic [6:0] rid(input logic [DATA_WIDTH-1:0] d);
        return d[ROBID_LSB +: ROBID_W];
    endfunction

    function automatic isq_entry_t mk(input logic [6:0] robid, input int tag);
        isq_entry_t e;
        for (int k = 0; k < 7; k++) e.data[k*32 +: 32] = $urandom();
        e.data[247:224] = 24'($urandom());
        e.data[ROBID_LSB +: ROBID_W] = robid;
        e.condition = 2'(tag);
        e.index     = 4'(tag + 3);
        return e;
    endfunction

    // Scoreboard monitor: handshakes are decided at the next posedge, so judge them here.
    always @(negedge clock) begin
        logic kill, exp_ov, exp_ir;
        if (!reset_n) begin
            sb_q.delete();
`ifdef ISSUE_PIPE_PERF_CNT_EN
            m_issued = 0; m_stall = 0; m_killed = 0;
`endif
        end else begin
            kill   = flush_valid && (rob_state == ROB_STATE_ROLLIBACK);
            exp_ir = (sb_q.size() < 2);
            exp_ov = (sb_q.size() > 0) && !(kill && tb_younger(rid(sb_q[0].data), flush_robid));
            total++;
            if (occupancy !== 2'(sb_q.size())) begin
                bad++; $display("FAIL mon_occupancy got=%0d exp=%0d at %0t", occupancy, sb_q.size(), $time);
            end
            total++;
            if (in_ready !== exp_ir) begin
                bad++; $display("FAIL mon_in_ready got=%b exp=%b at %0t", in_ready, exp_ir, $time);
            end
            total++;
            if (out_valid !== exp_ov) begin
                bad++; $display("FAIL mon_out_valid got=%b exp=%b at %0t", out_valid, exp_ov, $time);
            end
            if (exp_ov) begin
                total++;
                if ({out_data, out_condition, out_index} !== sb_q[0]) begin
                    bad++; $display("FAIL mon_out_entry got_robid=%h exp_robid=%h got_idx=%h exp_idx=%h at %0t",
                                    rid(out_data), rid(sb_q[0].data), out_index, sb_q[0].index, $time);
                end
            end
`ifdef ISSUE_PIPE_PERF_CNT_EN
            total++;
            if ({perf_issued, perf_stall, perf_killed} !== {m_issued, m_stall, m_killed}) begin
                bad++; $display("FAIL mon_perf got=%0d/%0d/%0d exp=%0d/%0d/%0d at %0t",
                                perf_issued, perf_stall, perf_killed, m_issued, m_stall, m_killed, $time);
            end
            if (exp_ov && out_ready) m_issued++;
            if (exp_ov && !out_ready) m_stall++;
`endif
            if (exp_ov && out_ready) void'(sb_q.pop_front());
            if (kill) begin
                keep_q.delete();
                foreach (sb_q[k]) begin
                    if (tb_younger(rid(sb_q[k].data), flush_robid)) begin
`ifdef ISSUE_PIPE_PERF_CNT_EN
                        m_killed++;
`endif
                    end else begin
                        keep_q.push_back(sb_q[k]);
                    end
                end
                sb_q = keep_q;
            end
            if (in_valid && exp_ir) begin
                if (kill && tb_younger(rid(in_data), flush_robid)) begin
`ifdef ISSUE_PIPE_PERF_CNT_EN
                    m_killed++;
`endif
                end else begin
                    sb_q.push_back('{data: in_data, condition: in_condition, index: in_index});
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_flush(input logic v, input logic [1:0] st, input logic [6:0] r);
        flush_valid = v;
        rob_state   = st;
        flush_robid = r;
    endtask

    task automatic drive_in(input isq_entry_t e);
        in_valid     = 1'b1;
        in_data      = e.data;
        in_condition = e.condition;
        in_index     = e.index;
    endtask

    task automatic push(input isq_entry_t e);
        drive_in(e);
        for (int n = 0; n < 20 && !in_ready; n++) step();
        total++;
        if (!in_ready) begin
            bad++; $display("FAIL push_timeout got_in_ready=%b exp=1", in_ready);
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int n = 0; n < 20 && occupancy != 2'd0; n++) step();
        total++;
        if (occupancy !== 2'd0) begin
            bad++; $display("FAIL drain_timeout got_occ=%0d exp=0", occupancy);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        step();
        total++;
        if ({out_valid, in_ready, occupancy} !== 4'b0100 || out_data !== '0) begin
            bad++; $display("FAIL reset_state got=%b%b%0d data_zero=%b exp=0_1_0_1",
                            out_valid, in_ready, occupancy, out_data == '0);
        end
        step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_stream();
        isq_entry_t e;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            e = mk(7'(8'h10 + i), i);
            drive_in(e);
            step();
            total++;
            if (out_valid !== 1'b1 || out_data !== e.data || in_ready !== 1'b1) begin
                bad++; $display("FAIL stream_latency i=%0d got_v=%b got_robid=%h exp_robid=%h in_ready=%b",
                                i, out_valid, rid(out_data), rid(e.data), in_ready);
            end
        end
        in_valid = 1'b0;
        step();
        total++;
        if (occupancy !== 2'd0) begin
            bad++; $display("FAIL stream_empty got=%0d exp=0", occupancy);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        isq_entry_t a, b, c;
        a = mk(7'h20, 1); b = mk(7'h21, 2); c = mk(7'h22, 3);
        out_ready = 1'b0;
        drive_in(a); step();
        drive_in(b); step();
        total++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== a.data) begin
            bad++; $display("FAIL bp_full got_occ=%0d in_ready=%b robid=%h exp=2 0 20", occupancy, in_ready, rid(out_data));
        end
        drive_in(c); step(); step();
        total++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== a.data) begin
            bad++; $display("FAIL bp_hold got_occ=%0d in_ready=%b robid=%h exp=2 0 20", occupancy, in_ready, rid(out_data));
        end
        out_ready = 1'b1;
        step();
        total++;
        if (occupancy !== 2'd1 || in_ready !== 1'b1 || out_data !== b.data) begin
            bad++; $display("FAIL bp_release got_occ=%0d in_ready=%b robid=%h exp=1 1 21", occupancy, in_ready, rid(out_data));
        end
        step();
        total++;
        if (occupancy !== 2'd1 || out_data !== c.data) begin
            bad++; $display("FAIL bp_third got_occ=%0d robid=%h exp=1 22", occupancy, rid(out_data));
        end
        in_valid = 1'b0;
        drain();
    endtask

    task automatic test_flush_basic();
        out_ready = 1'b0;
        push(mk(7'h05, 4));
        push(mk(7'h09, 5));
        set_flush(1'b1, ROB_STATE_ROLLIBACK, 7'h06);
        out_ready = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b1 || rid(out_data) !== 7'h05) begin
            bad++; $display("FAIL flush_older_head got_v=%b robid=%h exp=1 05", out_valid, rid(out_data));
        end
        step();
        set_flush(1'b0, ROB_STATE_NORMAL, 7'h00);
        out_ready = 1'b0;
        total++;
        if (occupancy !== 2'd0) begin
            bad++; $display("FAIL flush_young_dropped got_occ=%0d exp=0", occupancy);
        end
        push(mk(7'h09, 6));
        set_flush(1'b1, ROB_STATE_ROLLIBACK, 7'h06);
        out_ready = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL flush_head_masked got=%b exp=0", out_valid);
        end
        step();
        set_flush(1'b0, ROB_STATE_NORMAL, 7'h00);
        out_ready = 1'b0;
        total++;
        if (occupancy !== 2'd0) begin
            bad++; $display("FAIL flush_head_gone got_occ=%0d exp=0", occupancy);
        end
    endtask

    task automatic test_wrap();
        out_ready = 1'b0;
        push(mk(7'h7E, 7));
        push(mk(7'h02, 8));
        set_flush(1'b1, ROB_STATE_ROLLIBACK, 7'h7F);
        step();
        set_flush(1'b0, ROB_STATE_NORMAL, 7'h00);
        total++;
        if (occupancy !== 2'd1 || rid(out_data) !== 7'h7E) begin
            bad++; $display("FAIL wrap_kill got_occ=%0d robid=%h exp=1 7e", occupancy, rid(out_data));
        end
        push(mk(7'h7F, 9));
        set_flush(1'b1, ROB_STATE_ROLLIBACK, 7'h7F);
        step();
        set_flush(1'b0, ROB_STATE_NORMAL, 7'h00);
        total++;
        if (occupancy !== 2'd2) begin
            bad++; $display("FAIL wrap_equal_kept got_occ=%0d exp=2", occupancy);
        end
        drain();
    endtask

    task automatic test_no_rollback_and_incoming();
        out_ready = 1'b0;
        push(mk(7'h09, 10));
        push(mk(7'h0A, 11));
        set_flush(1'b1, ROB_STATE_RECOVER, 7'h06);
        step();
        total++;
        if (occupancy !== 2'd2 || out_valid !== 1'b1) begin
            bad++; $display("FAIL norollback_kept got_occ=%0d v=%b exp=2 1", occupancy, out_valid);
        end
        set_flush(1'b0, ROB_STATE_NORMAL, 7'h00);
        drain();
        set_flush(1'b1, ROB_STATE_ROLLIBACK, 7'h06);
        drive_in(mk(7'h10, 12));
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL incoming_ready got=%b exp=1", in_ready);
        end
        step();
        total++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL incoming_dropped got_occ=%0d v=%b exp=0 0", occupancy, out_valid);
        end
        drive_in(mk(7'h03, 13));
        step();
        in_valid = 1'b0;
        set_flush(1'b0, ROB_STATE_NORMAL, 7'h00);
        total++;
        if (occupancy !== 2'd1 || rid(out_data) !== 7'h03) begin
            bad++; $display("FAIL incoming_older_kept got_occ=%0d robid=%h exp=1 03", occupancy, rid(out_data));
        end
        drain();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        push(mk(7'h30, 14));
        push(mk(7'h31, 15));
        out_ready = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL async_reset got_v=%b occ=%0d in_ready=%b exp=0 0 1", out_valid, occupancy, in_ready);
        end
`ifdef ISSUE_PIPE_PERF_CNT_EN
        total++;
        if ({perf_issued, perf_stall, perf_killed} !== 96'd0) begin
            bad++; $display("FAIL async_reset_perf got=%0d/%0d/%0d exp=0/0/0", perf_issued, perf_stall, perf_killed);
        end
`endif
        step();
        step();
        reset_n = 1'b1;
        out_ready = 1'b0;
        step();
        push(mk(7'h40, 1));
        push(mk(7'h41, 2));
        drain();
    endtask

    initial begin
        reset_n      = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        in_condition = '0;
        in_index     = '0;
        out_ready    = 1'b0;
        set_flush(1'b0, ROB_STATE_NORMAL, 7'h00);
        test_reset();
        test_stream();
        test_backpressure();
        test_flush_basic();
        test_wrap();
        test_no_rollback_and_incoming();
        test_async_reset();
        step();
        total++;
        if (sb_q.size() != 0) begin
            bad++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
